// File: rtl/renderer_pkg.sv
// Shared types and screen constants for the object pixel renderer.
package renderer_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned COLOR_W  = 3;
    // Wide enough for scan counters of objects up to 32 pixels on a side.
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StErase = 2'd1,
        StDraw  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/rect_scanner.sv
// Column/row raster counter over a W x H rectangle; column is the inner loop.
module rect_scanner
    import renderer_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned H = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic             last
);

    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;
    logic             col_end, row_end;

    assign col_end = (cx_q == CNT_W'(W - 1));
    assign row_end = (cy_q == CNT_W'(H - 1));

    // Advancing past the last pixel wraps both counters back to zero.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (advance) begin
            if (col_end) begin
                cx_d = '0;
                cy_d = row_end ? '0 : cy_q + CNT_W'(1);
            end else begin
                cx_d = cx_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = col_end && row_end;

endmodule

// File: rtl/object_pixel_renderer.sv
// Erases an object's previous footprint then draws it at a new position, one pixel per
// granted cycle. Define RENDERER_ERASE_EN to include the erase pass and previous-position state.
module object_pixel_renderer
    import renderer_pkg::*;
#(
    parameter int unsigned OBJ_W = 8,
    parameter int unsigned OBJ_H = 8
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               start,
    input  logic [8:0]         obj_x,
    input  logic [7:0]         obj_y,
    input  logic [COLOR_W-1:0] obj_color,
    input  logic [COLOR_W-1:0] background_color,
    input  logic               slot_grant,
    output logic [8:0]         VGA_X,
    output logic [7:0]         VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot_enable,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [8:0]         new_x_q, new_x_d;
    logic [7:0]         new_y_q, new_y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [8:0]         vga_x_q, vga_x_d;
    logic [7:0]         vga_y_q, vga_y_d;
    logic [COLOR_W-1:0] vga_color_q, vga_color_d;
    logic               plot_q, plot_d;

    logic [CNT_W-1:0]   cx, cy;
    logic               last_px, accept, scan_active, scan_step;
    logic [8:0]         base_x;
    logic [7:0]         base_y;
    logic [COLOR_W-1:0] pix_color;
    logic [9:0]         sum_x, sum_y;

    logic               erase_pending, in_erase;
    logic [8:0]         erase_x;
    logic [7:0]         erase_y;
    logic [COLOR_W-1:0] erase_color;

`ifdef RENDERER_ERASE_EN
    logic [8:0] prev_x_q, prev_x_d;
    logic [7:0] prev_y_q, prev_y_d;
    logic       prev_valid_q, prev_valid_d;

    always_comb begin
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        if (state_q == StDone) begin
            prev_x_d     = new_x_q;
            prev_y_d     = new_y_q;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign erase_pending = prev_valid_q;
    assign in_erase      = (state_q == StErase);
    assign erase_x       = prev_x_q;
    assign erase_y       = prev_y_q;
    assign erase_color   = background_color;
`else
    logic unused_bg;
    assign unused_bg     = ^background_color;
    assign erase_pending = 1'b0;
    assign in_erase      = 1'b0;
    assign erase_x       = '0;
    assign erase_y       = '0;
    assign erase_color   = '0;
`endif

    assign accept      = (state_q == StIdle) && start;
    assign scan_active = (state_q == StErase) || (state_q == StDraw);
    assign scan_step   = scan_active && slot_grant;

    rect_scanner #(
        .W (OBJ_W),
        .H (OBJ_H)
    ) u_scanner (
        .clk     (CLOCK_50),
        .rst     (rst),
        .clear   (state_q == StIdle),
        .advance (scan_step),
        .cx      (cx),
        .cy      (cy),
        .last    (last_px)
    );

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = erase_pending ? StErase : StDraw;
            StErase: if (scan_step && last_px) state_d = StDraw;
            StDraw:  if (scan_step && last_px) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Off-screen pixels still consume their granted cycle, they just do not plot.
    always_comb begin
        base_x      = in_erase ? erase_x : new_x_q;
        base_y      = in_erase ? erase_y : new_y_q;
        pix_color   = in_erase ? erase_color : color_q;
        sum_x       = {1'b0, base_x} + {5'b0, cx};
        sum_y       = {2'b0, base_y} + {5'b0, cy};
        plot_d      = scan_step && (sum_x < 10'(SCREEN_W)) && (sum_y < 10'(SCREEN_H));
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        if (plot_d) begin
            vga_x_d     = sum_x[8:0];
            vga_y_d     = sum_y[7:0];
            vga_color_d = pix_color;
        end
        new_x_d = accept ? obj_x     : new_x_q;
        new_y_d = accept ? obj_y     : new_y_q;
        color_d = accept ? obj_color : color_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            new_x_q     <= '0;
            new_y_q     <= '0;
            color_q     <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            plot_q      <= 1'b0;
        end else begin
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            color_q     <= color_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            plot_q      <= plot_d;
        end
    end

    assign VGA_X       = vga_x_q;
    assign VGA_Y       = vga_y_q;
    assign VGA_COLOR   = vga_color_q;
    assign plot_enable = plot_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_object_pixel_renderer.sv
// Self-checking bench for object_pixel_renderer with a 4x4 object; expected pixel streams
// come from a row-major footprint model of erase-then-draw.
module tb_object_pixel_renderer;

`ifdef RENDERER_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [8:0] obj_x;
    logic [7:0] obj_y;
    logic [2:0] obj_color;
    logic [2:0] background_color;
    logic       slot_grant;
    logic [8:0] VGA_X;
    logic [7:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot_enable;
    logic       busy;
    logic       done;

    object_pixel_renderer #(
        .OBJ_W (4),
        .OBJ_H (4)
    ) dut (
        .CLOCK_50         (clk),
        .rst              (rst),
        .start            (start),
        .obj_x            (obj_x),
        .obj_y            (obj_y),
        .obj_color        (obj_color),
        .background_color (background_color),
        .slot_grant       (slot_grant),
        .VGA_X            (VGA_X),
        .VGA_Y            (VGA_Y),
        .VGA_COLOR        (VGA_COLOR),
        .plot_enable      (plot_enable),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the footprint left on screen by the last completed redraw.
    bit m_prev_valid;
    int m_prev_x, m_prev_y;

    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];
    int          cyc_q[$];
    int          cycle = 0;
    logic        grant_prev = 1'b0;
    bit          mon_on = 1'b0;
    int          done_cnt, done_at, bad_grant, busy_cnt;

    function automatic logic [19:0] pix(input int x, input int y, input int c);
        return {x[8:0], y[7:0], c[2:0]};
    endfunction

    always @(posedge clk) begin
        cycle      <= cycle + 1;
        grant_prev <= slot_grant;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (plot_enable) begin
                got_q.push_back({VGA_X, VGA_Y, VGA_COLOR});
                cyc_q.push_back(cycle);
                if (!grant_prev) bad_grant++;
            end
            if (done) begin
                done_cnt++;
                done_at = got_q.size();
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic clear_monitor;
        got_q.delete();
        cyc_q.delete();
        done_cnt  = 0;
        done_at   = -1;
        bad_grant = 0;
        busy_cnt  = 0;
    endtask

    // mode: 0 grant always high, 1 grant toggles, 2 grant random.
    task automatic run_redraw(input int x, input int y, input int c, input int bg,
                              input int mode, input bit mid_start);
        int cyc;
        exp_q.delete();
        if (ERASE_EN && m_prev_valid) begin
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    if (m_prev_x + k < 320 && m_prev_y + r < 240)
                        exp_q.push_back(pix(m_prev_x + k, m_prev_y + r, bg));
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (x + k < 320 && y + r < 240) exp_q.push_back(pix(x + k, y + r, c));
        clear_monitor();
        obj_x            = 9'(x);
        obj_y            = 8'(y);
        obj_color        = 3'(c);
        background_color = 3'(bg);
        slot_grant       = 1'b1;
        start            = 1'b1;
        mon_on           = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        cyc   = 0;
        while (done_cnt == 0 && cyc < 400) begin
            case (mode)
                0:       slot_grant = 1'b1;
                1:       slot_grant = ~slot_grant;
                default: slot_grant = 1'($urandom_range(0, 1));
            endcase
            if (mid_start && cyc == 6) begin
                start     = 1'b1;
                obj_x     = 9'(x + 40);
                obj_y     = 8'(y + 9);
                obj_color = 3'(c + 3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #2;
            cyc++;
        end
        slot_grant = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        mon_on = 1'b0;
        if (done_cnt > 0) begin
            m_prev_valid = 1'b1;
            m_prev_x     = x;
            m_prev_y     = y;
        end
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        start      = 1'b0;
        slot_grant = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst          = 1'b0;
        m_prev_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst              = 1'b1;
        start            = 1'b1;
        obj_x            = 9'd5;
        obj_y            = 8'd5;
        obj_color        = 3'd7;
        background_color = 3'd0;
        slot_grant       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (VGA_X !== 9'd0) begin
            errors++; $display("FAIL reset_vga_x: got %0d expected 0", VGA_X);
        end
        checks++;
        if (VGA_Y !== 8'd0) begin
            errors++; $display("FAIL reset_vga_y: got %0d expected 0", VGA_Y);
        end
        checks++;
        if (VGA_COLOR !== 3'd0) begin
            errors++; $display("FAIL reset_vga_color: got %0d expected 0", VGA_COLOR);
        end
        checks++;
        if ({plot_enable, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got plot/busy/done %b expected 000",
                     {plot_enable, busy, done});
        end
        #1;
        start = 1'b0;
        do_reset();
    endtask

    task automatic test_first_draw;
        run_redraw(10, 20, 1, 0, 0, 1'b0);
        checks++;
        if (got_q.size() !== 16) begin
            errors++; $display("FAIL first_draw_count: got %0d expected 16", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL first_draw_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() == 16 && cyc_q[15] - cyc_q[0] !== 15) begin
            errors++;
            $display("FAIL first_draw_consecutive: got span %0d expected 15", cyc_q[15] - cyc_q[0]);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 16) begin
            errors++;
            $display("FAIL first_draw_done: got %0d pulses after %0d plots expected 1 after 16",
                     done_cnt, done_at);
        end
        checks++;
        if (busy_cnt !== 17) begin
            errors++; $display("FAIL first_draw_busy: got %0d cycles expected 17", busy_cnt);
        end
    endtask

    task automatic test_erase_redraw;
        run_redraw(12, 20, 1, 0, 0, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL erase_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL erase_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== exp_q.size()) begin
            errors++;
            $display("FAIL erase_done: got %0d pulses after %0d plots expected 1 after %0d",
                     done_cnt, done_at, exp_q.size());
        end
    endtask

    task automatic test_toggle_grant;
        do_reset();
        run_redraw(10, 20, 1, 0, 0, 1'b0);
        run_redraw(12, 20, 1, 0, 1, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL toggle_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL toggle_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bad_grant !== 0) begin
            errors++; $display("FAIL toggle_plot_without_grant: got %0d expected 0", bad_grant);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL toggle_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_screen_edge;
        do_reset();
        run_redraw(318, 238, 5, 0, 0, 1'b0);
        checks++;
        if (got_q.size() !== 4) begin
            errors++; $display("FAIL edge_count: got %0d expected 4", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL edge_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy_cnt !== 17) begin
            errors++; $display("FAIL edge_scan_cycles: got %0d busy cycles expected 17", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL edge_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_start_ignored;
        run_redraw(100, 60, 6, 2, 0, 1'b1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL ignore_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ignore_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ignore_no_queue: got busy %b expected 0", busy);
        end
        #1;
    endtask

    task automatic test_reset_abort;
        do_reset();
        run_redraw(50, 50, 3, 0, 0, 1'b0);
        clear_monitor();
        obj_x     = 9'd60;
        obj_y     = 8'd70;
        obj_color = 3'd4;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (22) @(posedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, plot_enable, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_flags: got busy/plot/done %b expected 000",
                     {busy, plot_enable, done});
        end
        #1;
        rst          = 1'b0;
        start        = 1'b0;
        m_prev_valid = 1'b0;
        mon_on       = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        mon_on = 1'b0;
        checks++;
        if (done_cnt !== 0 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d done %0d plots expected 0 0",
                     done_cnt, got_q.size());
        end
        run_redraw(30, 40, 2, 7, 0, 1'b0);
        checks++;
        if (got_q.size() !== 16) begin
            errors++; $display("FAIL abort_no_erase_count: got %0d expected 16", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_pixel[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            int x, y, c, bg;
            x  = int'($urandom_range(0, 330));
            y  = int'($urandom_range(0, 250));
            c  = int'($urandom_range(0, 7));
            bg = int'($urandom_range(0, 7));
            run_redraw(x, y, c, bg, 2, 1'b0);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_count: got %0d expected %0d", n, got_q.size(),
                         exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d_pixel[%0d]: got %h expected %h", n, i, got_q[i],
                             exp_q[i]);
                end
            end
            checks++;
            if (done_cnt !== 1 || bad_grant !== 0) begin
                errors++;
                $display("FAIL random%0d_done_grant: got done %0d bad %0d expected 1 0", n,
                         done_cnt, bad_grant);
            end
        end
    endtask

    initial begin
        m_prev_valid = 1'b0;
        m_prev_x     = 0;
        m_prev_y     = 0;
        test_reset();
        test_first_draw();
        test_erase_redraw();
        test_toggle_grant();
        test_screen_edge();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
